// File: rtl/key_sw_responder.sv
// key_sw_responder: memory-mapped KEY/SW input device with debounce, status/control registers and interrupt
module key_sw_responder #(
  parameter int DBITS = 16,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CBITS = 14,
  parameter logic [DBITS-1:0] KDATA_ADDR = 16'hFFF0,
  parameter logic [DBITS-1:0] SDATA_ADDR = 16'hFFF2,
  parameter logic [DBITS-1:0] KCTRL_ADDR = 16'hFFF4,
  parameter logic [DBITS-1:0] SCTRL_ADDR = 16'hFFF6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ABUS,
  input  logic             RE,
  input  logic             WE,
  input  logic [DBITS-1:0] DIN,
  output logic [DBITS-1:0] DOUT,
  output logic             DSEL,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic             INTR
);
  localparam logic [CBITS-1:0] LAST = CBITS'(DEBOUNCE_CYCLES - 1);
  logic [3:0] k1, k2, kdb;
  logic [9:0] s1, s2, sdb;
  logic [CBITS-1:0] kcnt, scnt;
  logic ka, sa, kc, sc, krd, srd, kwr, swr;
  logic kstep, sstep, kchg, schg;
  logic krdy, kovr, kie, srdy, sovr, sie;
  logic unused_din;
  assign unused_din = ^{DIN[DBITS-1:9], DIN[7:3], DIN[1:0]};
  // address decode, strobes, debounce progress and combinational read data
  always_comb begin
    ka = ABUS == KDATA_ADDR;
    sa = ABUS == SDATA_ADDR;
    kc = ABUS == KCTRL_ADDR;
    sc = ABUS == SCTRL_ADDR;
    krd = RE & ka;
    srd = RE & sa;
    kwr = WE & kc;
    swr = WE & sc;
    kstep = (k2 != kdb) && (k1 == k2);
    sstep = (s2 != sdb) && (s1 == s2);
    kchg = kstep && kcnt == LAST;
    schg = sstep && scnt == LAST;
    DSEL = ka | sa | kc | sc;
    DOUT = ka ? DBITS'(kdb) :
           sa ? DBITS'(sdb) :
           kc ? DBITS'({kie, 5'b0, kovr, 1'b0, krdy}) :
           sc ? DBITS'({sie, 5'b0, sovr, 1'b0, srdy}) : '0;
  end
  // two-flop synchronizers; keys inverted so 1 means pressed
  always_ff @(posedge CLK) begin
    if (RESET) begin
      k1 <= '0;
      k2 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      k1 <= ~KEY;
      k2 <= k1;
      s1 <= SW;
      s2 <= s1;
    end
  end
  // key debounce: count stable differing cycles, restart when the synced value moves
  always_ff @(posedge CLK) begin
    if (RESET) begin
      kcnt <= '0;
      kdb <= '0;
    end else if (kchg) begin
      kcnt <= '0;
      kdb <= k2;
    end else
      kcnt <= kstep ? kcnt + 1'b1 : '0;
  end
  // switch debounce: same scheme as the keys
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scnt <= '0;
      sdb <= '0;
    end else if (schg) begin
      scnt <= '0;
      sdb <= s2;
    end else
      scnt <= sstep ? scnt + 1'b1 : '0;
  end
  // ready/overrun/enable flags and registered interrupt
  always_ff @(posedge CLK) begin
    if (RESET) begin
      {krdy, kovr, kie, srdy, sovr, sie, INTR} <= '0;
    end else begin
      krdy <= kchg | (krdy & ~krd);
      srdy <= schg | (srdy & ~srd);
      kovr <= (kchg & krdy & ~krd) | (kovr & ~(kwr & ~DIN[2]));
      sovr <= (schg & srdy & ~srd) | (sovr & ~(swr & ~DIN[2]));
      kie <= kwr ? DIN[8] : kie;
      sie <= swr ? DIN[8] : sie;
      INTR <= (krdy & kie) | (srdy & sie);
    end
  end
endmodule

// File: tb/tb_key_sw_responder.sv
// tb_key_sw_responder: directed and randomized checks of key_sw_responder against a window-based model
module tb_key_sw_responder;
  localparam int D = 4;
  localparam logic [15:0] KDATA = 16'hFFF0;
  localparam logic [15:0] SDATA = 16'hFFF2;
  localparam logic [15:0] KCTRL = 16'hFFF4;
  localparam logic [15:0] SCTRL = 16'hFFF6;
  logic CLK = 0;
  logic RESET = 1;
  logic [15:0] ABUS = 0;
  logic RE = 0;
  logic WE = 0;
  logic [15:0] DIN = 0;
  logic [15:0] DOUT;
  logic DSEL;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = 0;
  logic INTR;
  int tests = 0;
  int fails = 0;
  logic armed = 0;
  always #5 CLK = ~CLK;
  key_sw_responder #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RESET(RESET), .ABUS(ABUS), .RE(RE), .WE(WE), .DIN(DIN),
    .DOUT(DOUT), .DSEL(DSEL), .KEY(KEY), .SW(SW), .INTR(INTR)
  );
  // model: group 0 = keys (pressed = 1), group 1 = switches
  // a debounced value updates once D+1 consecutive first-stage samples agree and differ from it
  logic [9:0] m_s1 [2];
  logic [9:0] m_h [2][D+1];
  logic [9:0] m_db [2];
  logic m_rdy [2];
  logic m_ovr [2];
  logic m_ie [2];
  logic m_intr;
  always @(posedge CLK) begin
    logic [9:0] raw [2];
    logic ev, rd, wr, nintr;
    raw[0] = {6'b0, ~KEY};
    raw[1] = SW;
    nintr = (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1]);
    for (int g = 0; g < 2; g++) begin
      rd = RE && ABUS == (g == 1 ? SDATA : KDATA);
      wr = WE && ABUS == (g == 1 ? SCTRL : KCTRL);
      for (int i = D; i > 0; i--) m_h[g][i] = m_h[g][i-1];
      m_h[g][0] = m_s1[g];
      ev = m_h[g][0] != m_db[g];
      for (int i = 1; i <= D; i++) if (m_h[g][i] != m_h[g][0]) ev = 0;
      if (RESET) begin
        for (int i = 0; i <= D; i++) m_h[g][i] = 0;
        m_s1[g] = 0;
        m_db[g] = 0;
        m_rdy[g] = 0;
        m_ovr[g] = 0;
        m_ie[g] = 0;
      end else begin
        if (ev && m_rdy[g] && !rd) m_ovr[g] = 1;
        else if (wr && !DIN[2]) m_ovr[g] = 0;
        m_rdy[g] = ev | (m_rdy[g] & !rd);
        if (wr) m_ie[g] = DIN[8];
        if (ev) m_db[g] = m_h[g][0];
        m_s1[g] = raw[g];
      end
    end
    m_intr = RESET ? 1'b0 : nintr;
  end
  function automatic logic [15:0] exp_dout(input logic [15:0] a);
    if (a == KDATA) return {6'b0, m_db[0]};
    if (a == SDATA) return {6'b0, m_db[1]};
    if (a == KCTRL) return {7'b0, m_ie[0], 5'b0, m_ovr[0], 1'b0, m_rdy[0]};
    if (a == SCTRL) return {7'b0, m_ie[1], 5'b0, m_ovr[1], 1'b0, m_rdy[1]};
    return 16'h0000;
  endfunction
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic lit(input string nm, input logic [15:0] a, input logic [15:0] want);
    ABUS = a;
    #1;
    chk(nm, DOUT, want);
    chk({nm, "_model"}, exp_dout(a), want);
  endtask
  task automatic lit_intr(input string nm, input logic want);
    #1;
    chk(nm, {15'b0, INTR}, {15'b0, want});
  endtask
  // every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    logic hit;
    if (armed) begin
      hit = ABUS inside {KDATA, SDATA, KCTRL, SCTRL};
      chk("dout", DOUT, exp_dout(ABUS));
      chk("dsel", {15'b0, DSEL}, {15'b0, hit});
      chk("intr", {15'b0, INTR}, {15'b0, m_intr});
    end
  end
  initial begin
    tick(1);
    armed = 1;
    tick(2);
    RESET = 0;
    tick(8);
    lit("rst_kdata", KDATA, 16'h0000);
    lit("rst_sdata", SDATA, 16'h0000);
    lit("rst_kctrl", KCTRL, 16'h0000);
    lit("rst_sctrl", SCTRL, 16'h0000);
    lit("rst_other", 16'h1234, 16'h0000);
    lit_intr("rst_intr", 0);
    KEY = 4'hE;
    tick(5);
    lit("key_early", KDATA, 16'h0000);
    tick(1);
    lit("key_at6", KDATA, 16'h0001);
    lit("kctrl_at6", KCTRL, 16'h0001);
    ABUS = KDATA;
    RE = 1;
    tick(1);
    RE = 0;
    lit("kctrl_clr", KCTRL, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) KEY[1] = ~KEY[1];
      lit("key_bounce", KDATA, 16'h0001);
      tick(1);
    end
    tick(10);
    lit("key_settle", KDATA, 16'h0003);
    ABUS = KDATA;
    RE = 1;
    tick(1);
    RE = 0;
    SW = 10'h2A5;
    tick(8);
    SW = 10'h2A4;
    tick(8);
    lit("sw_data", SDATA, 16'h02A4);
    lit("sw_ovr", SCTRL, 16'h0005);
    ABUS = SCTRL;
    DIN = 16'h0000;
    WE = 1;
    tick(1);
    WE = 0;
    lit("sw_ovr_clr", SCTRL, 16'h0001);
    ABUS = SDATA;
    RE = 1;
    tick(1);
    RE = 0;
    lit("sw_rdy_clr", SCTRL, 16'h0000);
    ABUS = KCTRL;
    DIN = 16'h0100;
    WE = 1;
    tick(1);
    WE = 0;
    KEY = 4'h8;
    tick(6);
    lit("kctrl_ie", KCTRL, 16'h0101);
    lit_intr("intr_lag", 0);
    tick(1);
    lit_intr("intr_rise", 1);
    ABUS = KDATA;
    RE = 1;
    tick(1);
    RE = 0;
    lit_intr("intr_hold", 1);
    tick(1);
    lit_intr("intr_fall", 0);
    KEY = 4'hC;
    tick(8);
    lit("key_rel", KDATA, 16'h0003);
    KEY = 4'h8;
    tick(5);
    ABUS = KDATA;
    RE = 1;
    tick(1);
    RE = 0;
    lit("coinc_data", KDATA, 16'h0007);
    lit("coinc_ctrl", KCTRL, 16'h0101);
    KEY = 4'hC;
    tick(3);
    RESET = 1;
    KEY = 4'hF;
    SW = 0;
    tick(2);
    RESET = 0;
    lit("rst2_kdata", KDATA, 16'h0000);
    lit("rst2_kctrl", KCTRL, 16'h0000);
    lit("rst2_sctrl", SCTRL, 16'h0000);
    lit_intr("rst2_intr", 0);
    tick(10);
    lit("rst2_late", KDATA, 16'h0000);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) KEY = 4'($urandom);
      if ($urandom_range(0, 39) == 0) SW = 10'($urandom);
      case ($urandom_range(0, 5))
        0: ABUS = KDATA;
        1: ABUS = SDATA;
        2: ABUS = KCTRL;
        3: ABUS = SCTRL;
        default: ABUS = 16'($urandom);
      endcase
      RE = $urandom_range(0, 2) == 0;
      WE = $urandom_range(0, 3) == 0;
      DIN = 16'($urandom);
      RESET = $urandom_range(0, 499) == 0;
      tick(1);
    end
    RE = 0;
    WE = 0;
    RESET = 0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_sw_responder.md
Name: key_sw_responder

Overview:
- Memory-mapped input responder on the processor's data-memory bus; the device end of the KEY/SW loads issued by the CPU.
- Synchronizes and debounces the raw board keys (active-low) and switches, and exposes them as data registers.
- Provides per-device status/control registers: ready flag, overrun flag and interrupt enable.
- Drives read data combinationally so a single-cycle load completes in the same cycle it is issued.

Parameters:
DBITS, 16, bus data/address width
DEBOUNCE_CYCLES, 10000, consecutive stable cycles required before a debounced value updates (minimum 1)
CBITS, 14, debounce counter width; must hold DEBOUNCE_CYCLES
KDATA_ADDR, 16'hFFF0, key data register (read-only)
SDATA_ADDR, 16'hFFF2, switch data register (read-only)
KCTRL_ADDR, 16'hFFF4, key status/control register
SCTRL_ADDR, 16'hFFF6, switch status/control register

Ports:
CLK  input  1  system clock; all state updates on its rising edge
RESET  input  1  reset; synchronous, active-high
ABUS  input  DBITS  data-bus address
RE  input  1  read strobe; read side effects apply at the rising edge of CLK
WE  input  1  write strobe
DIN  input  DBITS  write data
DOUT  output  DBITS  read data; combinational from ABUS
DSEL  output  1  high when ABUS matches any of the four addresses
KEY  input  4  raw keys, active-low (0 = pressed)
SW  input  10  raw switches
INTR  output  1  interrupt request

Behaviour:
- Synchronizers: two flops per group. The KEY path inverts so that 1 = pressed. Reset loads 0 into all sync flops.
- Debounce (one counter per group, KEY and SW):
  - If the synced value equals the debounced value, the counter is cleared to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the synced value is still different, the debounced value takes the synced value on that edge and the counter clears. A new debounced value is therefore visible DEBOUNCE_CYCLES+2 cycles after a stable raw change.
  - If the synced value changes during a count, the counter restarts at 0.
- Register layout:
  - KDATA = {12'b0, debounced keys}
  - SDATA = {6'b0, debounced switches}
  - xCTRL bit0 = READY, bit2 = OVERRUN, bit8 = IE; all other bits read 0.
- READY:
  - Set on any cycle in which the debounced value of its group changes.
  - Cleared at the edge where RE=1 and ABUS = that group's data address.
  - If a change and a clearing read occur on the same edge, READY stays 1.
- OVERRUN:
  - Set when the debounced value changes while READY is already 1 and no clearing read occurs on that edge.
  - Cleared only by writing the CTRL register with DIN bit2 = 0. Writing 1 leaves it unchanged.
- IE: written from DIN bit8 on any CTRL write.
- Write-protected bits: READY is not writable; writes to data addresses are ignored.
- Strobe handling:
  - RE and WE both high: the write takes effect and the read side effect is also applied.
  - Unmatched address: DSEL=0, DOUT=0, no state change.
- INTR is registered: INTR <= (K.READY & K.IE) | (S.READY & S.IE). One cycle of latency.
- Reset values: DOUT=0 for all non-matching addresses; debounced values, counters, READY, OVERRUN, IE and INTR all 0.
  - Keys released at reset therefore read KDATA=0 with no event.
  - Switches already set at reset produce an SW event after debounce.
  - Reset mid-count discards the pending value.

Test Plan:
1. DEBOUNCE_CYCLES=4. Reset, KEY=4'hF, SW=0; read all four addresses -> every read returns 0, INTR=0 throughout.
2. Drop KEY to 4'hE and hold -> KDATA reads 16'h0001 exactly 6 cycles later and KCTRL reads 16'h0001 on the same cycle. Then read KDATA once -> KCTRL reads 16'h0000 on the next cycle.
3. Toggle KEY[1] with a period of 3 cycles for 20 cycles, then hold -> KDATA never changes during the toggling; it updates only after 4 stable synced cycles.
4. Change SW to 10'h2A5 and then to 10'h2A4 without reading -> SDATA=16'h02A4 and SCTRL=16'h0005. Write 16'h0000 to SCTRL -> reads 16'h0001. Read SDATA -> reads 16'h0000.
5. Write 16'h0100 to KCTRL, then press a key -> INTR rises 1 cycle after READY sets. A KDATA read drops READY, and INTR falls on the following edge.
6. Debounced key change lands on the same edge as an RE read of KDATA -> READY=1 and OVERRUN=0 afterwards. Assert RESET mid-count -> no update, all state returns to 0.
